// File: rtl/latency_probe_pkg.sv
// -----------------------------------------------------------------------------
// latency_probe_pkg
//   Shared types and helpers for the latency_probe block.
//   - state_t   : measurement FSM states (IDLE, ARM, MEASURE)
//   - cnt_width : bits needed to hold the values 0..max_val (at least 1)
// -----------------------------------------------------------------------------
package latency_probe_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      MEASURE = 2'd2
   } state_t;

   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/latency_probe.sv
// -----------------------------------------------------------------------------
// latency_probe
//   Measures the round-trip latency (in clk cycles) of a single-bit path in the
//   same clock domain. On start it waits for QUIET_CYCLES consecutive low echo
//   samples, fires a one-cycle probe, and counts cycles until echo returns.
//   The probe cycle is cycle 0; an echo sampled in cycle N reports latency N.
//   No echo by cycle MAX_LATENCY reports a timeout with latency = MAX_LATENCY.
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   measurement request, sampled only in IDLE
//   echo     in   return end of the path under test
//   probe    out  launch pulse into the path under test (one cycle)
//   busy     out  high while arming or measuring
//   done     out  one-cycle pulse, echo received, latency valid
//   timeout  out  one-cycle pulse, no echo within MAX_LATENCY cycles
//   latency  out  last result, held until the next result
// -----------------------------------------------------------------------------
module latency_probe
   import latency_probe_pkg::*;
#(
   parameter  int MAX_LATENCY  = 255,
   parameter  int QUIET_CYCLES = 4,
   localparam int CNT_W        = cnt_width(MAX_LATENCY)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             echo,
   output logic             probe,
   output logic             busy,
   output logic             done,
   output logic             timeout,
   output logic [CNT_W-1:0] latency
);

   localparam int QW = cnt_width(QUIET_CYCLES);

   localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_LATENCY);
   localparam logic [QW-1:0]    Q_LAST = QW'(QUIET_CYCLES - 1);

   state_t           state;
   logic [QW-1:0]    qcnt;
   logic [CNT_W-1:0] cnt;

   // All outputs are registered; pulses default low and are set only on the
   // transition that produces them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         qcnt    <= '0;
         cnt     <= '0;
         probe   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         timeout <= 1'b0;
         latency <= '0;
      end else begin
         probe   <= 1'b0;
         done    <= 1'b0;
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= ARM;
                  qcnt  <= '0;
                  busy  <= 1'b1;
               end
            end
            ARM: begin
               // qcnt holds the number of lows already seen; this sample is
               // the last one needed when qcnt reaches QUIET_CYCLES-1.
               if (echo) begin
                  qcnt <= '0;
               end else if (qcnt == Q_LAST) begin
                  state <= MEASURE;
                  cnt   <= '0;
                  probe <= 1'b1;
               end else begin
                  qcnt <= qcnt + 1'b1;
               end
            end
            MEASURE: begin
               // Echo wins over timeout, so an echo in the final cycle still
               // reports a real measurement.
               if (echo) begin
                  latency <= cnt;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end else if (cnt == MAX_C) begin
                  latency <= MAX_C;
                  timeout <= 1'b1;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_latency_probe.sv
// -----------------------------------------------------------------------------
// tb_latency_probe
//   Self-checking bench for latency_probe (MAX_LATENCY=10, QUIET_CYCLES=4).
//   The path under test is a flop chain of selectable depth fed by probe;
//   depth 0 is a direct wire. Other echo sources: tied low, or driven by the
//   bench directly.
// -----------------------------------------------------------------------------
module tb_latency_probe;

   localparam int MAXL  = 10;
   localparam int QUIET = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       echo;
   logic       probe;
   logic       busy;
   logic       done;
   logic       timeout;
   logic [3:0] latency;

   int         sel = -1;      // -2: echo_drv, -1: tied 0, k>=0: k-flop path
   logic       echo_drv = 1'b0;
   logic [15:0] dl = '0;
   int         cyc = 0;

   int         n_assert = 0;
   int         n_fail   = 0;

   latency_probe #(.MAX_LATENCY(MAXL), .QUIET_CYCLES(QUIET)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .echo    (echo),
      .probe   (probe),
      .busy    (busy),
      .done    (done),
      .timeout (timeout),
      .latency (latency)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      dl  <= {dl[14:0], probe};
   end

   always_comb begin
      echo = 1'b0;
      if (sel == -2)     echo = echo_drv;
      else if (sel < 0)  echo = 1'b0;
      else if (sel == 0) echo = probe;
      else               echo = dl[sel-1];
   end

   typedef struct {
      string name;
      int    sel;
      int    exp_done;
      int    exp_tmo;
      int    exp_lat;
      int    exp_roff;   // result cycle minus probe cycle
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string nm, input int act, input int exp);
      n_assert++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic wait_idle(input string nm);
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      chk({nm, " returns idle"}, int'(busy), 0);
      repeat (20) @(negedge clk);
   endtask

   task automatic run_vec(input vec_t v);
      int s, p_cyc, r_cyc, n_done, n_tmo, n_probe, lat, busy_r;
      p_cyc = -1; r_cyc = -1; n_done = 0; n_tmo = 0; n_probe = 0;
      lat = -1; busy_r = -1;
      sel = v.sel;
      @(negedge clk);
      start = 1'b1;
      s = cyc;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (i == 0) start = 1'b0;
         if (probe) begin n_probe++; p_cyc = cyc; end
         if (done || timeout) begin
            r_cyc  = cyc;
            lat    = int'(latency);
            busy_r = int'(busy);
         end
         n_done += int'(done);
         n_tmo  += int'(timeout);
      end
      chk({v.name, " probe offset"}, p_cyc - s, QUIET + 1);
      chk({v.name, " probe count"}, n_probe, 1);
      chk({v.name, " done count"}, n_done, v.exp_done);
      chk({v.name, " timeout count"}, n_tmo, v.exp_tmo);
      chk({v.name, " latency"}, lat, v.exp_lat);
      chk({v.name, " result offset"}, r_cyc - p_cyc, v.exp_roff);
      chk({v.name, " busy at result"}, busy_r, 0);
   endtask

   initial begin
      int s, k, n_probe, n_done, n_tmo, p_cyc, lat, n_bad, prev_done;

      vecs[0] = '{"wire",      0, 1, 0, 0,  1};
      vecs[1] = '{"one_flop",  1, 1, 0, 1,  2};
      vecs[2] = '{"delayer3",  4, 1, 0, 4,  5};
      vecs[3] = '{"edge_max", 10, 1, 0, 10, 11};
      vecs[4] = '{"too_late", 11, 0, 1, 10, 11};
      vecs[5] = '{"tie_zero", -1, 0, 1, 10, 11};

      rst_n = 1'b0;
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset probe",   int'(probe),   0);
      chk("reset busy",    int'(busy),    0);
      chk("reset done",    int'(done),    0);
      chk("reset timeout", int'(timeout), 0);
      chk("reset latency", int'(latency), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      foreach (vecs[i]) run_vec(vecs[i]);

      // Noisy return line: high through start+6, low afterwards, one late echo.
      sel = -2;
      @(negedge clk);
      start = 1'b1; echo_drv = 1'b1; s = cyc;
      n_probe = 0; n_done = 0; n_tmo = 0; p_cyc = -1; lat = -1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         start = 1'b0;
         k = cyc - s;
         echo_drv = (k <= 6) || (k == 13);
         if (probe) begin n_probe++; p_cyc = cyc; end
         if (done) lat = int'(latency);
         n_done += int'(done);
         n_tmo  += int'(timeout);
      end
      echo_drv = 1'b0;
      chk("noisy probe offset", p_cyc - s, 11);
      chk("noisy probe count", n_probe, 1);
      chk("noisy done count", n_done, 1);
      chk("noisy timeout count", n_tmo, 0);
      chk("noisy latency", lat, 2);

      // Echo stuck high: stays armed, never probes.
      echo_drv = 1'b1;
      @(negedge clk);
      start = 1'b1;
      n_probe = 0; n_bad = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (probe) n_probe++;
         if (!busy) n_bad++;
      end
      chk("stuck probe count", n_probe, 0);
      chk("stuck busy low cycles", n_bad, 0);
      echo_drv = 1'b0;
      wait_idle("stuck");

      // Reset two cycles into MEASURE.
      sel = 4;
      @(negedge clk);
      start = 1'b1;
      p_cyc = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (probe) begin p_cyc = cyc; break; end
      end
      chk("abort probe seen", int'(p_cyc >= 0), 1);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort busy",    int'(busy),    0);
      chk("abort probe",   int'(probe),   0);
      chk("abort done",    int'(done),    0);
      chk("abort timeout", int'(timeout), 0);
      chk("abort latency", int'(latency), 0);
      n_done = 0; n_tmo = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         n_done += int'(done);
         n_tmo  += int'(timeout);
      end
      chk("abort no result", n_done + n_tmo, 0);
      run_vec(vecs[2]);

      // Back-to-back with start held high.
      sel = 4;
      @(negedge clk);
      start = 1'b1; s = cyc;
      n_done = 0; n_tmo = 0; n_bad = 0; prev_done = 0;
      for (int i = 0; i < 35; i++) begin
         @(negedge clk);
         if (prev_done && !busy) n_bad++;
         if (done && latency != 4'd4) n_bad++;
         prev_done = int'(done);
         n_done += int'(done);
         n_tmo  += int'(timeout);
      end
      start = 1'b0;
      chk("b2b done count", n_done, 3);
      chk("b2b timeout count", n_tmo, 0);
      chk("b2b rearm/latency errors", n_bad, 0);
      wait_idle("b2b");

      // Start pulses during ARM and MEASURE are ignored.
      @(negedge clk);
      start = 1'b1;
      n_probe = 0; n_done = 0; n_tmo = 0;
      for (int i = 1; i <= 25; i++) begin
         @(negedge clk);
         start = (i == 2) || (i == 6) || (i == 7);
         if (probe) n_probe++;
         n_done += int'(done);
         n_tmo  += int'(timeout);
      end
      start = 1'b0;
      chk("ignore probe count", n_probe, 1);
      chk("ignore done count", n_done, 1);
      chk("ignore timeout count", n_tmo, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
